// File: rtl/linebuffer_ctrl_pkg.sv
// Shared definitions for the 3x3 line-buffer sequencer.
//   - state_e : sequencer FSM states (IDLE / RUN / DRAIN)
//   - tag_t   : per-cycle window tag carried alongside the pixel stream
//   - SEL_MAX : highest legal layer-size select
//   - CW      : coordinate / counter width
//   - len_of  : maps a size select onto the map side length
package linebuffer_ctrl_pkg;

  localparam int         CW      = 8;
  localparam logic [2:0] SEL_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } tag_t;

  function automatic logic [CW-1:0] len_of(input logic [2:0] sel,
                                           input int l1, input int l2,
                                           input int l3, input int l4,
                                           input int l5, input int l6);
    int l;
    case (sel)
      3'd0:    l = l1;
      3'd1:    l = l2;
      3'd2:    l = l3;
      3'd3:    l = l4;
      3'd4:    l = l5;
      3'd5:    l = l6;
      default: l = l1;
    endcase
    return l[CW-1:0];
  endfunction

endpackage

// File: rtl/ctrl_tag_pipe.sv
// Fixed-latency delay line for the window tag, matching the read latency of
// the feature buffer plus the collector's window latency.
//   clk   : clock
//   rst   : synchronous active-high clear of every stage
//   tag_i : tag for the read issued this cycle
//   tag_o : tag delayed by DEPTH cycles
module ctrl_tag_pipe
  import linebuffer_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  // Every stage is cleared so no stale window survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/linebuffer_3x3_seq_ctrl.sv
// Sequencer for the 8-channel 3x3 line-buffer collector.
// On an accepted start it latches the size select, streams one raster read
// per cycle over a LEN x LEN map, and tags each cycle whose collector window
// is a valid unpadded convolution position.
//   clk, rst      : clock, synchronous active-high reset
//   start,cfg_sel : request to process one map and its size select
//   sel           : registered select to the collector
//   busy, done    : map in progress / one-cycle completion pulse
//   cfg_err       : pulse when a start carries an illegal select
//   rd_en,rd_addr : feature-buffer read strobe and raster address
//   win_valid,win_row,win_col,win_last : window tag at collector outputs
module linebuffer_3x3_seq_ctrl
  import linebuffer_ctrl_pkg::*;
#(
  parameter int LEN1    = 16,
  parameter int LEN2    = 14,
  parameter int LEN3    = 28,
  parameter int LEN4    = 56,
  parameter int LEN5    = 112,
  parameter int LEN6    = 224,
  parameter int RD_LAT  = 1,
  parameter int WIN_LAT = 1,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    cfg_sel,
  output logic [2:0]    sel,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          win_valid,
  output logic [7:0]    win_row,
  output logic [7:0]    win_col,
  output logic          win_last
);

  localparam int DEPTH = RD_LAT + WIN_LAT;

  state_e        state_q;
  logic [2:0]    sel_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] row_f_q;
  logic [CW-1:0] col_f_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic          cfg_err_q;

  logic [CW-1:0] len_m1;
  logic          last_pix;
  tag_t          tag_d;
  tag_t          tag_out;

  assign len_m1   = len_q - CW'(1);
  assign last_pix = (row_f_q == len_m1) && (col_f_q == len_m1);

  // Columns 0/1 carry wrap-around garbage from the previous row and rows 0/1
  // have no full window yet; only interior positions are tagged.
  always_comb begin
    tag_d = '0;
    if (rd_en_q && (row_f_q >= CW'(2)) && (col_f_q >= CW'(2))) begin
      tag_d.v    = 1'b1;
      tag_d.last = last_pix;
      tag_d.row  = row_f_q - CW'(2);
      tag_d.col  = col_f_q - CW'(2);
    end
  end

  ctrl_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_d),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      row_f_q   <= '0;
      col_f_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_sel <= SEL_MAX) begin
              sel_q     <= cfg_sel;
              len_q     <= len_of(cfg_sel, LEN1, LEN2, LEN3, LEN4, LEN5, LEN6);
              row_f_q   <= '0;
              col_f_q   <= '0;
              rd_addr_q <= '0;
              rd_en_q   <= 1'b1;
              state_q   <= ST_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        // The line buffers cannot stall, so reads run back to back.
        ST_RUN: begin
          if (last_pix) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
            if (col_f_q == len_m1) begin
              col_f_q <= '0;
              row_f_q <= row_f_q + CW'(1);
            end else begin
              col_f_q <= col_f_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (tag_out.v && tag_out.last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign cfg_err   = cfg_err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign win_valid = tag_out.v;
  assign win_row   = tag_out.row;
  assign win_col   = tag_out.col;
  assign win_last  = tag_out.v & tag_out.last;
  assign done      = tag_out.v & tag_out.last;

endmodule

// File: tb/tb_linebuffer_3x3_seq_ctrl.sv
module tb_linebuffer_3x3_seq_ctrl;

  localparam int RD_LAT  = 1;
  localparam int WIN_LAT = 1;
  localparam int D       = RD_LAT + WIN_LAT;
  localparam int AW      = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    cfg_sel;
  logic [2:0]    sel;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          win_valid;
  logic [7:0]    win_row;
  logic [7:0]    win_col;
  logic          win_last;

  linebuffer_3x3_seq_ctrl #(
    .LEN1(16), .LEN2(14), .LEN3(28), .LEN4(56), .LEN5(112), .LEN6(224),
    .RD_LAT(RD_LAT), .WIN_LAT(WIN_LAT), .AW(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_sel   (cfg_sel),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint cyc; int addr; } rd_t;
  typedef struct { longint cyc; int r; int c; bit last; } win_t;
  rd_t  rq[$];
  win_t wq[$];

  // Reference model state
  bit     mon_en      = 0;
  bit     m_active    = 0;
  longint m_tc        = 0;
  longint m_dc        = 0;
  int     m_sel       = 0;
  int     m_sel_prev  = 0;
  longint m_sel_cyc   = 0;
  longint exp_err_cyc = -1;

  int n_vec = 0;
  int n_err = 0;
  int n_win = 0;

  function automatic int len_ref(input int s);
    case (s)
      0: return 16;
      1: return 14;
      2: return 28;
      3: return 56;
      4: return 112;
      default: return 224;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the model/queues.
  always @(negedge clk) begin
    rd_t    e;
    win_t   w;
    longint bexp;
    int     sexp;
    if (mon_en) begin
      bexp = (m_active && cyc >= m_tc + 1 && cyc <= m_dc) ? 1 : 0;
      chk("busy", busy, bexp);
      sexp = (cyc >= m_sel_cyc) ? m_sel : m_sel_prev;
      chk("sel", sel, sexp);
      if (cfg_err || cyc == exp_err_cyc)
        chk("cfg_err", cfg_err, (cyc == exp_err_cyc) ? 1 : 0);
      if (rd_en) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_addr", rd_addr, e.addr);
          chk("rd_cycle", cyc, e.cyc);
        end
      end
      if (win_valid) begin
        if (wq.size() == 0) chk("win_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          n_win++;
          chk("win_row", win_row, w.r);
          chk("win_col", win_col, w.c);
          chk("win_cycle", cyc, w.cyc);
          chk("win_last", win_last, w.last);
          chk("done", done, w.last);
        end
      end else if (done || win_last) begin
        chk("done_without_window", 1, 0);
      end
    end
  end

  // Issue one start pulse; the model decides acceptance from its own timeline.
  task automatic start_map(input int s);
    int L;
    @(posedge clk); #2;
    start   = 1'b1;
    cfg_sel = s[2:0];
    if (!m_active || cyc > m_dc) begin
      if (s <= 5) begin
        L          = len_ref(s);
        m_sel_prev = m_sel;
        m_sel      = s;
        m_sel_cyc  = cyc + 1;
        m_tc       = cyc;
        m_dc       = cyc + L * L + D;
        m_active   = 1;
        for (int k = 0; k < L * L; k++) begin
          rd_t e;
          e.cyc  = cyc + 1 + k;
          e.addr = k;
          rq.push_back(e);
        end
        for (int r = 0; r < L - 2; r++)
          for (int c = 0; c < L - 2; c++) begin
            win_t w;
            w.cyc  = cyc + 1 + (r + 2) * L + (c + 2) + D;
            w.r    = r;
            w.c    = c;
            w.last = (r == L - 3) && (c == L - 3);
            wq.push_back(w);
          end
      end else begin
        exp_err_cyc = cyc + 1;
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Called 2 time units after a rising edge; holds rst for that cycle.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rq.delete();
    wq.delete();
    m_active    = 0;
    m_sel       = 0;
    m_sel_prev  = 0;
    m_sel_cyc   = 0;
    exp_err_cyc = -1;
    mon_en      = 1;
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_win_last", win_last, 0);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    #1;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_map(input int s);
    int w0;
    int L;
    w0 = n_win;
    L  = len_ref(s);
    start_map(s);
    wait_done(L * L + 50);
    chk("win_count", n_win - w0, (L - 2) * (L - 2));
  endtask

  initial begin
    int w0;
    int s;
    rst     = 1'b0;
    start   = 1'b0;
    cfg_sel = 3'd0;
    @(posedge clk); #2;
    do_reset();

    // Basic maps
    run_map(1);
    run_map(0);

    // Illegal selects from IDLE
    repeat (3) @(posedge clk);
    start_map(6);
    repeat (4) @(posedge clk);
    start_map(7);
    repeat (4) @(posedge clk);

    // Start while busy is ignored
    w0 = n_win;
    start_map(1);
    repeat (50) @(posedge clk);
    start_map(3);
    start_map(6);
    wait_done(300);
    chk("win_count_ignored_start", n_win - w0, 144);

    // Reset in the middle of a map, then a fresh map
    start_map(1);
    repeat (100) @(posedge clk);
    #2;
    do_reset();
    repeat (10) @(posedge clk);
    run_map(2);

    // Back-to-back maps at the earliest restart
    run_map(1);
    run_map(0);

    // Randomised maps with ignored starts during the run
    for (int i = 0; i < 6; i++) begin
      int L;
      s  = (i == 5) ? 3 : int'($urandom_range(0, 2));
      L  = len_ref(s);
      w0 = n_win;
      start_map(s);
      repeat ($urandom_range(0, L * L - 10)) @(posedge clk);
      start_map($urandom_range(0, 7));
      wait_done(L * L + 50);
      chk("win_count_rand", n_win - w0, (L - 2) * (L - 2));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("rd_queue_empty", rq.size(), 0);
    chk("win_queue_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/linebuffer_3x3_seq_ctrl.md
Name: linebuffer_3x3_seq_ctrl

Overview:
- Sequencer for the 8-channel 3x3 line-buffer collector.
- On start it latches the layer-size select, drives the collector's sel, and issues one feature-buffer read per cycle for a square LEN x LEN map; the read data feeds ifmstream_0..7 in parallel.
- The line buffers shift every clock and cannot stall, so reads are continuous from first pixel to last.
- It tags each cycle whose 3x3 window is a valid, unpadded convolution position with win_valid and output coordinates, and signals completion.

Parameters:
- LEN1, 16, map side for sel=0
- LEN2, 14, map side for sel=1
- LEN3, 28, map side for sel=2
- LEN4, 56, map side for sel=3
- LEN5, 112, map side for sel=4
- LEN6, 224, map side for sel=5
- RD_LAT, 1, cycles from rd_en to pixel at ifmstream inputs (>=1)
- WIN_LAT, 1, cycles from pixel at ifmstream input to its window at ifm_win3x3 outputs (>=0)
- AW, 16, rd_addr width (must hold LEN6*LEN6-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to process one map
- cfg_sel  in  3  size select sampled with start
- sel  out  3  registered select driven to the collector
- busy  out  1  high while a map is in progress
- done  out  1  one-cycle pulse, coincident with the final win_valid
- cfg_err  out  1  one-cycle pulse when start is rejected for cfg_sel 6 or 7
- rd_en  out  1  feature-buffer read strobe
- rd_addr  out  AW  raster address, row*LEN+col
- win_valid  out  1  collector outputs hold a valid window this cycle
- win_row  out  8  output row of the window (0..LEN-3)
- win_col  out  8  output column of the window (0..LEN-3)
- win_last  out  1  marks the final window; equals done

Behaviour:
- Reset: state IDLE, sel=0, and busy, done, cfg_err, rd_en, win_valid, win_last all 0; rd_addr, win_row and win_col are 0.
- Reset mid-operation aborts the map and clears all delay-pipeline valids, so no stale win_valid appears after reset.
- FSM IDLE:
  - start with cfg_sel<=5 latches sel and LEN=len_of(cfg_sel), then goes to RUN.
  - start with cfg_sel>=6 pulses cfg_err next cycle, stays IDLE, sel unchanged.
- FSM RUN: rd_en=1 every cycle; (row_f,col_f) raster counters.
  - col_f wraps at LEN-1 to 0 and row_f increments.
  - After address LEN*LEN-1, go to DRAIN.
- FSM DRAIN: rd_en=0; wait until the pipeline empties and the last window is emitted, then go to IDLE.
- Timing, with start accepted at cycle T:
  - rd_en=1 at T+1 .. T+LEN*LEN with rd_addr = 0,1,2,... consecutively.
  - busy=1 from T+1 through the done cycle inclusive.
- Window tag: issue flag v = (row_f>=2 && col_f>=2), carried with coordinates (row_f-2, col_f-2) through an RD_LAT+WIN_LAT stage delay line.
  - Read k issued at cycle t produces win_valid at t+RD_LAT+WIN_LAT.
  - Columns 0 and 1 of each row (wrap garbage) and rows 0..1 never assert win_valid.
- Window count per map is (LEN-2)^2. done and win_last assert with the window (LEN-3,LEN-3); the FSM is IDLE the next cycle.
- start while busy is ignored, with no cfg_err.
- start in the done cycle is ignored; it is accepted only from IDLE.
- Back-to-back maps: earliest restart is the cycle after done.
- sel is held stable for the whole map, including DRAIN; it only changes on an accepted start.
- Width rules:
  - Counters use 8 bits (LEN<=224 fits).
  - rd_addr is formed incrementally (+1 per read), not by multiply.
  - Illegal parameter combos are not checked in RTL.

Decomposition:
- Shared package linebuffer_ctrl_pkg:
  - state encoding IDLE/RUN/DRAIN
  - SEL_MAX=5
  - function len_of(sel, LEN1..LEN6)
  - coordinate width constant CW=8
- Sub-module ctrl_tag_pipe: parameterised depth (RD_LAT+WIN_LAT) shift of {v, row, col, last}, with synchronous clear on rst.
- All else (FSM, counters, address) lives in the top.

Test Plan:
- sel=1 (LEN=14), start at T, RD_LAT=1, WIN_LAT=1:
  - rd_en for 196 consecutive cycles, rd_addr 0..195.
  - 144 win_valid pulses; first at T+1+30+2 with (0,0).
  - done coincides with (11,11), and busy drops the next cycle.
- sel=0 (LEN=16): 256 reads and 196 windows. In each row, win_valid is low on the cycles tagged with col_f 0 and 1. Window (5,13) appears at read index 7*16+15=127, +2 cycles.
- cfg_sel=6 with start in IDLE: cfg_err pulses once; rd_en, busy and sel stay 0.
- start pulsed mid-RUN with cfg_sel=3: ignored; sel and LEN are unchanged and the window count stays 144 for sel=1.
- rst asserted at read 100 of sel=1: the next cycle all outputs are at reset values and no win_valid follows. A new start with sel=2 then yields 784 reads and 676 windows.
- Two maps back-to-back (sel=1, then start the cycle after done with sel=0): rd_en gap of exactly 1+RD_LAT+WIN_LAT cycles, and both window counts are correct.
